cache_req_seq: RTL and testbench

CACHE_REQ_SEQ -- requirements
Module: cache_req_seq

---
 rtl/cache_req_seq.sv | 172 +++++++++++++++++
 tb/tb_cache_req_seq.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_req_seq.sv
// cache_req_seq: replays a programmed table of read/write requests against a
// downstream cache, counts hits/misses, checks read data and flags timeouts.
module cache_req_seq #(
    parameter int SEQ_IDX_LEN = 4,
    parameter int TIMEOUT     = 1023
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   prog_we,
    input  logic [SEQ_IDX_LEN-1:0] prog_idx,
    input  logic                   prog_wr,
    input  logic [31:0]            prog_addr,
    input  logic [31:0]            prog_data,
    input  logic                   start,
    input  logic [SEQ_IDX_LEN-1:0] last_idx,
    output logic [31:0]            addr,
    output logic                   rd_req,
    output logic                   wr_req,
    output logic [31:0]            wr_data,
    input  logic                   miss,
    input  logic [31:0]            rd_data,
    output logic                   busy,
    output logic                   done,
    output logic [15:0]            hit_cnt,
    output logic [15:0]            miss_cnt,
    output logic [15:0]            err_cnt,
    output logic [SEQ_IDX_LEN-1:0] first_err_idx,
    output logic                   timeout_err
);

    localparam int DEPTH = 1 << SEQ_IDX_LEN;
    localparam int WW    = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, CHECK, FINISH} state_t;

    state_t state, state_nx;

    logic                   tbl_wr   [DEPTH];
    logic [31:0]            tbl_addr [DEPTH];
    logic [31:0]            tbl_data [DEPTH];

    logic [SEQ_IDX_LEN-1:0] cur_idx;
    logic [SEQ_IDX_LEN-1:0] last_r;
    logic                   missed;
    logic [WW-1:0]          wait_cnt;
    logic                   err_seen;

    logic req_on, accept, miss_cyc, tmo, at_last;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign req_on   = rd_req | wr_req;
    assign accept   = (state == ISSUE) && req_on && !miss;
    assign miss_cyc = (state == ISSUE) && req_on && miss;
    assign tmo      = miss_cyc && (wait_cnt == WW'(TIMEOUT - 1));
    assign at_last  = (cur_idx == last_r);
    assign busy     = (state != IDLE);
    assign done     = (state == FINISH);

    // Request table: writable only while idle, never reset.
    always_ff @(posedge clk) begin
        if (prog_we && state == IDLE) begin
            tbl_wr[prog_idx]   <= prog_wr;
            tbl_addr[prog_idx] <= prog_addr;
            tbl_data[prog_idx] <= prog_data;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:   if (start) state_nx = ISSUE;
            ISSUE: begin
                if (tmo)
                    state_nx = FINISH;
                else if (accept) begin
                    if (rd_req)       state_nx = CHECK;
                    else if (at_last) state_nx = FINISH;
                    else              state_nx = ISSUE;
                end
            end
            CHECK:  state_nx = at_last ? FINISH : ISSUE;
            FINISH: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: request issue, hit/miss accounting, read checking.
    // The first ISSUE cycle of each entry has no request asserted; it loads
    // the registered request and doubles as the idle gap between requests.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr          <= '0;
            wr_data       <= '0;
            rd_req        <= 1'b0;
            wr_req        <= 1'b0;
            cur_idx       <= '0;
            last_r        <= '0;
            missed        <= 1'b0;
            wait_cnt      <= '0;
            err_seen      <= 1'b0;
            hit_cnt       <= '0;
            miss_cnt      <= '0;
            err_cnt       <= '0;
            first_err_idx <= '0;
            timeout_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        last_r      <= last_idx;
                        cur_idx     <= '0;
                        hit_cnt     <= '0;
                        miss_cnt    <= '0;
                        err_cnt     <= '0;
                        err_seen    <= 1'b0;
                        timeout_err <= 1'b0;
                        missed      <= 1'b0;
                        wait_cnt    <= '0;
                    end
                end
                ISSUE: begin
                    if (!req_on) begin
                        addr    <= tbl_addr[cur_idx];
                        wr_data <= tbl_data[cur_idx];
                        rd_req  <= ~tbl_wr[cur_idx];
                        wr_req  <= tbl_wr[cur_idx];
                    end else if (miss) begin
                        missed   <= 1'b1;
                        wait_cnt <= wait_cnt + WW'(1);
                        if (tmo) begin
                            timeout_err <= 1'b1;
                            rd_req      <= 1'b0;
                            wr_req      <= 1'b0;
                        end
                    end else begin
                        if (missed) miss_cnt <= sat_inc(miss_cnt);
                        else        hit_cnt  <= sat_inc(hit_cnt);
                        missed   <= 1'b0;
                        wait_cnt <= '0;
                        rd_req   <= 1'b0;
                        wr_req   <= 1'b0;
                        if (wr_req && !at_last)
                            cur_idx <= cur_idx + SEQ_IDX_LEN'(1);
                    end
                end
                CHECK: begin
                    if (rd_data != tbl_data[cur_idx]) begin
                        err_cnt <= sat_inc(err_cnt);
                        if (!err_seen) begin
                            err_seen      <= 1'b1;
                            first_err_idx <= cur_idx;
                        end
                    end
                    if (!at_last)
                        cur_idx <= cur_idx + SEQ_IDX_LEN'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_req_seq.sv
// Directed bench for cache_req_seq with a small cache responder model.
module tb_cache_req_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        prog_we;
    logic [3:0]  prog_idx;
    logic        prog_wr;
    logic [31:0] prog_addr;
    logic [31:0] prog_data;
    logic        start;
    logic [3:0]  last_idx;
    logic [31:0] addr;
    logic        rd_req;
    logic        wr_req;
    logic [31:0] wr_data;
    logic        miss;
    logic [31:0] rd_data;
    logic        busy;
    logic        done;
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;
    logic [15:0] err_cnt;
    logic [3:0]  first_err_idx;
    logic        timeout_err;

    int n_cmp = 0;
    int n_err = 0;

    // Responder plan, indexed by request number within a run.
    int          miss_plan [16];
    logic [31:0] rd_plan   [16];
    int          req_no = 0;
    int          base   = 0;
    logic [31:0] seen_waddr, seen_wdata, seen_raddr;

    cache_req_seq #(.SEQ_IDX_LEN(4), .TIMEOUT(1023)) dut (
        .clk(clk), .rst(rst),
        .prog_we(prog_we), .prog_idx(prog_idx), .prog_wr(prog_wr),
        .prog_addr(prog_addr), .prog_data(prog_data),
        .start(start), .last_idx(last_idx),
        .addr(addr), .rd_req(rd_req), .wr_req(wr_req), .wr_data(wr_data),
        .miss(miss), .rd_data(rd_data),
        .busy(busy), .done(done),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .err_cnt(err_cnt),
        .first_err_idx(first_err_idx), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Cache model: each new request sees miss_plan[k] miss cycles, then hits.
    initial begin
        int  left;
        int  k;
        bit  in_req;
        left = 0; in_req = 0;
        miss = 1'b0; rd_data = '0;
        seen_waddr = '0; seen_wdata = '0; seen_raddr = '0;
        forever begin
            @(negedge clk);
            k = (req_no - base) & 15;
            if (rd_req || wr_req) begin
                if (!in_req) begin
                    in_req = 1;
                    left   = miss_plan[k];
                end
                miss = (left > 0);
                if (left > 0) left--;
                if (rd_req) begin
                    rd_data    = rd_plan[k];
                    seen_raddr = addr;
                end
                if (wr_req) begin
                    seen_waddr = addr;
                    seen_wdata = wr_data;
                end
            end else begin
                miss = 1'b0;
                if (in_req) begin
                    in_req = 0;
                    req_no++;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic prog(input int idx, input logic wr, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        prog_we = 1'b1; prog_idx = idx[3:0]; prog_wr = wr; prog_addr = a; prog_data = d;
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    task automatic pulse_start(input int last);
        @(negedge clk);
        base = req_no;
        start = 1'b1; last_idx = last[3:0];
        @(negedge clk);
        start = 1'b0;
    endtask

    // Waits for busy to fall, counting done pulses; ok=0 if the budget runs out.
    task automatic wait_done(input int budget, output int pulses, output bit ok);
        pulses = 0; ok = 0;
        for (int c = 0; c < budget; c++) begin
            if (done) pulses++;
            if (!busy) begin ok = 1; break; end
            @(negedge clk);
        end
    endtask

    initial begin
        int pulses;
        bit ok;
        rst = 1'b0; prog_we = 1'b0; prog_idx = '0; prog_wr = 1'b0;
        prog_addr = '0; prog_data = '0; start = 1'b0; last_idx = '0;
        for (int i = 0; i < 16; i++) begin miss_plan[i] = 0; rd_plan[i] = '0; end
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_rd_req", {31'b0, rd_req}, 0);
        chk("rst_wr_req", {31'b0, wr_req}, 0);
        chk("rst_busy",   {31'b0, busy}, 0);
        chk("rst_done",   {31'b0, done}, 0);
        chk("rst_addr",   addr, 0);
        chk("rst_wdata",  wr_data, 0);
        chk("rst_hit",    {16'b0, hit_cnt}, 0);
        chk("rst_tmo",    {31'b0, timeout_err}, 0);
        rst = 1'b1;

        // Write then read back, first access misses 5 cycles
        prog(0, 1'b1, 32'h40, 32'hA5A5);
        prog(1, 1'b0, 32'h40, 32'hA5A5);
        miss_plan[0] = 5; miss_plan[1] = 0; rd_plan[1] = 32'hA5A5;
        pulse_start(1);
        wait_done(200, pulses, ok);
        chk("s1_finished", {31'b0, ok}, 1);
        chk("s1_done_pulses", pulses, 1);
        chk("s1_miss", {16'b0, miss_cnt}, 1);
        chk("s1_hit",  {16'b0, hit_cnt}, 1);
        chk("s1_err",  {16'b0, err_cnt}, 0);
        chk("s1_waddr", seen_waddr, 32'h40);
        chk("s1_wdata", seen_wdata, 32'hA5A5);
        chk("s1_raddr", seen_raddr, 32'h40);

        // Read data mismatch at entry 3
        for (int i = 0; i < 3; i++) begin
            prog(i, 1'b0, 32'h100 + i * 4, 32'h10 + i);
            miss_plan[i] = 0; rd_plan[i] = 32'h10 + i;
        end
        prog(3, 1'b0, 32'h200, 32'h1234);
        miss_plan[3] = 0; rd_plan[3] = 32'h1235;
        pulse_start(3);
        wait_done(200, pulses, ok);
        chk("s2_finished", {31'b0, ok}, 1);
        chk("s2_err", {16'b0, err_cnt}, 1);
        chk("s2_first_err", {28'b0, first_err_idx}, 3);
        chk("s2_hit", {16'b0, hit_cnt}, 4);
        chk("s2_raddr", seen_raddr, 32'h200);

        // Timeout: miss held for TIMEOUT cycles
        prog(0, 1'b0, 32'h300, 32'h0);
        miss_plan[0] = 100000;
        pulse_start(0);
        wait_done(1200, pulses, ok);
        chk("s3_finished", {31'b0, ok}, 1);
        chk("s3_tmo", {31'b0, timeout_err}, 1);
        chk("s3_rd_req", {31'b0, rd_req}, 0);
        chk("s3_done_pulses", pulses, 1);
        chk("s3_busy", {31'b0, busy}, 0);
        chk("s3_hit", {16'b0, hit_cnt}, 0);
        chk("s3_miss", {16'b0, miss_cnt}, 0);

        // Reset mid-run while a read is outstanding
        prog(0, 1'b0, 32'h400, 32'h55);
        miss_plan[0] = 100000;
        pulse_start(0);
        ok = 0;
        for (int c = 0; c < 20; c++) begin
            if (rd_req) begin ok = 1; break; end
            @(negedge clk);
        end
        chk("s4_rd_req_seen", {31'b0, ok}, 1);
        rst = 1'b0;
        #1;
        chk("s4_rd_req", {31'b0, rd_req}, 0);
        chk("s4_busy", {31'b0, busy}, 0);
        chk("s4_tmo", {31'b0, timeout_err}, 0);
        chk("s4_addr", addr, 0);
        chk("s4_cnts", {hit_cnt, miss_cnt}, 0);
        @(negedge clk);
        rst = 1'b1;
        miss_plan[0] = 0; rd_plan[0] = 32'h55;
        pulse_start(0);
        wait_done(100, pulses, ok);
        chk("s4_rerun_finished", {31'b0, ok}, 1);
        chk("s4_rerun_hit", {16'b0, hit_cnt}, 1);
        chk("s4_rerun_err", {16'b0, err_cnt}, 0);

        // start and prog_we while busy are ignored
        prog(0, 1'b1, 32'h500, 32'h1);
        prog(1, 1'b0, 32'h500, 32'h1);
        miss_plan[0] = 3; miss_plan[1] = 0; rd_plan[1] = 32'h1;
        pulse_start(1);
        @(negedge clk);
        start = 1'b1; last_idx = 4'd0;
        prog_we = 1'b1; prog_idx = 4'd1; prog_wr = 1'b0; prog_addr = 32'h500; prog_data = 32'hDEAD;
        @(negedge clk);
        start = 1'b0; prog_we = 1'b0;
        wait_done(200, pulses, ok);
        chk("s5_finished", {31'b0, ok}, 1);
        chk("s5_hit", {16'b0, hit_cnt}, 1);
        chk("s5_miss", {16'b0, miss_cnt}, 1);
        chk("s5_err", {16'b0, err_cnt}, 0);

        // prog_we coincident with start
        miss_plan[0] = 0;
        @(negedge clk);
        base = req_no;
        start = 1'b1; last_idx = 4'd0;
        prog_we = 1'b1; prog_idx = 4'd0; prog_wr = 1'b1; prog_addr = 32'h80; prog_data = 32'h77;
        @(negedge clk);
        start = 1'b0; prog_we = 1'b0;
        wait_done(100, pulses, ok);
        chk("s6_finished", {31'b0, ok}, 1);
        chk("s6_waddr", seen_waddr, 32'h80);
        chk("s6_wdata", seen_wdata, 32'h77);
        chk("s6_hit", {16'b0, hit_cnt}, 1);

        // Full 16-entry table, all hits
        for (int i = 0; i < 16; i++) begin
            prog(i, 1'b0, 32'h1000 + i * 16, 32'hC000 + i);
            miss_plan[i] = 0; rd_plan[i] = 32'hC000 + i;
        end
        pulse_start(15);
        wait_done(300, pulses, ok);
        chk("s7_finished", {31'b0, ok}, 1);
        chk("s7_done_pulses", pulses, 1);
        chk("s7_hit", {16'b0, hit_cnt}, 16);
        chk("s7_err", {16'b0, err_cnt}, 0);
        chk("s7_cur_idx", {28'b0, dut.cur_idx}, 15);
        chk("s7_raddr", seen_raddr, 32'h10F0);
        repeat (5) @(negedge clk);
        chk("s7_hold_hit", {16'b0, hit_cnt}, 16);
        chk("s7_hold_busy", {31'b0, busy}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
